// File: rtl/soc_bus_pkg.sv
// Shared definitions for the 6502 SoC bus controller: default slave map,
// FSM state type, index-width and pclk increment helpers.
package soc_bus_pkg;

    localparam int NUM_SLV_DEF  = 4;
    localparam int DEC_BITS_DEF = 4;
    localparam int WS_W_DEF     = 3;

    // Region tags, slave i in bits [i*DEC_BITS +: DEC_BITS]
    localparam logic [NUM_SLV_DEF*DEC_BITS_DEF-1:0] SLV_BASE_DEF = {4'hf, 4'h2, 4'h1, 4'h0};
    // Wait states, slave i in bits [i*WS_W +: WS_W]
    localparam logic [NUM_SLV_DEF*WS_W_DEF-1:0]     SLV_WS_DEF   = {3'd1, 3'd2, 3'd0, 3'd0};

    typedef enum logic {
        IDLE,
        WAIT
    } bus_state_t;

    // Width of a slave index; at least one bit even for a single slave
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_DEF = idx_width(NUM_SLV_DEF);

    // Phase increment: round(pclk_hz * 2^acc_w / clk_hz)
    function automatic longint unsigned pclk_inc(input longint unsigned clk_hz,
                                                 input longint unsigned pclk_hz,
                                                 input int              acc_w);
        return ((pclk_hz << acc_w) + (clk_hz >> 1)) / clk_hz;
    endfunction

endpackage

// File: rtl/soc_pclk_gen.sv
// Fractional peripheral clock-enable: phase accumulator whose carry-out
// becomes a one-clk pclk pulse.
import soc_bus_pkg::*;

module soc_pclk_gen #(
    parameter int unsigned CLK_HZ  = 40000000,
    parameter int unsigned PCLK_HZ = 16000000,
    parameter int          ACC_W   = 16
) (
    input  logic clk,
    input  logic reset,
    output logic pclk
);

    localparam bit              HOLD  = (PCLK_HZ >= CLK_HZ);
    localparam longint unsigned INC_L = HOLD ? 64'd0
                                             : pclk_inc(64'(CLK_HZ), 64'(PCLK_HZ), ACC_W);
    localparam logic [ACC_W-1:0] INC  = INC_L[ACC_W-1:0];

    generate
        if (PCLK_HZ == 0) begin : g_bad_pclk
            $error("soc_pclk_gen: PCLK_HZ must be non-zero");
        end
    endgenerate

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    // Next accumulator value with carry-out in the top bit
    always_comb begin
        sum = {1'b0, acc} + {1'b0, INC};
    end

    // Accumulate phase; carry-out registers into pclk (held high when pclk >= clk)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            pclk <= 1'b0;
        end else if (HOLD) begin
            acc  <= '0;
            pclk <= 1'b1;
        end else begin
            acc  <= sum[ACC_W-1:0];
            pclk <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/soc_bus_ctrl.sv
// Bus controller between the 6502 core and its slaves: address decode,
// per-region wait states via RDY, registered read-data mux, pclk enable
// and masked IRQ aggregation.
import soc_bus_pkg::*;

module soc_bus_ctrl #(
    parameter int                            NUM_SLV  = 4,
    parameter int                            AW       = 16,
    parameter int                            DW       = 8,
    parameter int                            DEC_BITS = 4,
    parameter logic [NUM_SLV*DEC_BITS-1:0]   SLV_BASE = SLV_BASE_DEF,
    parameter int                            WS_W     = 3,
    parameter logic [NUM_SLV*WS_W-1:0]       SLV_WS   = SLV_WS_DEF,
    parameter int                            DEF_SLV  = 3,
    parameter int unsigned                   CLK_HZ   = 40000000,
    parameter int unsigned                   PCLK_HZ  = 16000000,
    parameter int                            ACC_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AW-1:0]         cpu_ab,
    input  logic                  cpu_we_n,
    output logic [DW-1:0]         cpu_di,
    output logic                  cpu_rdy,
    output logic                  cpu_irq_n,
    output logic [NUM_SLV-1:0]    slv_sel_n,
    output logic                  slv_we_n,
    input  logic [NUM_SLV*DW-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_irq_n,
    input  logic [NUM_SLV-1:0]    irq_en,
    output logic [NUM_SLV-1:0]    irq_pend,
    output logic                  pclk,
    output logic                  dec_err,
    input  logic                  err_clr
);

    localparam int            IW      = idx_width(NUM_SLV);
    localparam logic [IW-1:0] DEF_IDX = IW'(DEF_SLV);

    generate
        if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num
            $error("soc_bus_ctrl: NUM_SLV must be 1..16");
        end
        if (DEF_SLV < 0 || DEF_SLV >= NUM_SLV) begin : g_bad_def
            $error("soc_bus_ctrl: DEF_SLV must be below NUM_SLV");
        end
        if (DEC_BITS > AW) begin : g_bad_dec
            $error("soc_bus_ctrl: DEC_BITS must not exceed AW");
        end
        if (DEC_BITS < AW) begin : g_low_addr
            // Low address bits only matter to the slaves themselves
            logic unused_addr;
            assign unused_addr = ^cpu_ab[AW-DEC_BITS-1:0];
        end
    endgenerate

    bus_state_t          state;
    logic [WS_W-1:0]     cnt;
    logic [IW-1:0]       lat_idx;
    logic                lat_miss;
    logic [IW-1:0]       dec_idx;
    logic                dec_hit;
    logic [DEC_BITS-1:0] tag;
    logic [IW-1:0]       act_idx;
    logic                act_miss;
    logic [WS_W-1:0]     act_ws;
    logic [IW-1:0]       mux_sel;

    // Address decode: lowest matching slave index wins, miss falls back to DEF_SLV
    always_comb begin
        tag     = cpu_ab[AW-1 -: DEC_BITS];
        dec_idx = DEF_IDX;
        dec_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (!dec_hit && tag == SLV_BASE[i*DEC_BITS +: DEC_BITS]) begin
                dec_idx = IW'(i);
                dec_hit = 1'b1;
            end
        end
    end

    // Active slave (latched while waiting), ready, selects and write strobe
    always_comb begin
        act_idx  = (state == WAIT) ? lat_idx  : dec_idx;
        act_miss = (state == WAIT) ? lat_miss : !dec_hit;
        act_ws   = SLV_WS[act_idx*WS_W +: WS_W];
        if (state == WAIT) begin
            cpu_rdy = (cnt == '0);
        end else begin
            cpu_rdy = (act_ws == '0);
        end
        slv_sel_n          = '1;
        slv_sel_n[act_idx] = 1'b0;
        slv_we_n           = cpu_we_n | ~cpu_rdy;
    end

    // Wait-state FSM: IDLE stalls into WAIT for W>0 slaves, counting W-1 further cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_idx  <= DEF_IDX;
            lat_miss <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (act_ws != '0) begin
                        state    <= WAIT;
                        cnt      <= act_ws - WS_W'(1);
                        lat_idx  <= dec_idx;
                        lat_miss <= !dec_hit;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read mux select follows the slave of each completing cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mux_sel <= DEF_IDX;
        end else if (cpu_rdy) begin
            mux_sel <= act_idx;
        end
    end

    assign cpu_di = slv_rdata[mux_sel*DW +: DW];

    // Sticky decode-miss flag; a new miss beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_err <= 1'b0;
        end else if (cpu_rdy && act_miss) begin
            dec_err <= 1'b1;
        end else if (err_clr) begin
            dec_err <= 1'b0;
        end
    end

    // Level-sensitive masked IRQ aggregation, one clk latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_pend  <= '0;
            cpu_irq_n <= 1'b1;
        end else begin
            irq_pend  <= ~slv_irq_n & irq_en;
            cpu_irq_n <= ~|(~slv_irq_n & irq_en);
        end
    end

    soc_pclk_gen #(
        .CLK_HZ  (CLK_HZ),
        .PCLK_HZ (PCLK_HZ),
        .ACC_W   (ACC_W)
    ) u_pclk (
        .clk   (clk),
        .reset (reset),
        .pclk  (pclk)
    );

endmodule
